// File: rtl/mem_pkg.sv
// Shared memory-side definitions: access-size encoding and cache line geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        RW_B    = 2'b00,
        RW_HALF = 2'b01,
        RW_WORD = 2'b10
    } rw_type;

    localparam int LINE_BYTES  = 16;
    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;

endpackage

// File: rtl/dcache_direct_if.sv
// Core-side request/response bus and memory-side block bus of the data cache.
interface dcache_core_if import mem_pkg::*; #(parameter int ADDR_WIDTH = 32) ();
    logic                  req_valid;
    logic                  req_we;
    rw_type                req_type;
    logic                  req_sign_ext;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [31:0]           resp_rdata;
    logic                  stall;

    modport master (output req_valid, req_we, req_type, req_sign_ext, req_addr, req_wdata,
                    input  resp_rdata, stall);
    modport slave  (input  req_valid, req_we, req_type, req_sign_ext, req_addr, req_wdata,
                    output resp_rdata, stall);
endinterface

interface dcache_mem_if import mem_pkg::*; #(parameter int ADDR_WIDTH = 32) ();
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_BITS-1:0]  mem_wdata;
    logic [LINE_BITS-1:0]  mem_rdata;
    logic                  mem_ready;

    modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_word_align.sv
// Byte-lane steering between a cache line and the core: load extraction and store merge.
module dcache_word_align import mem_pkg::*; (
    input  logic [31:0]            ld_word,
    input  logic [1:0]             ld_lane,
    input  rw_type                 ld_type,
    input  logic                   ld_sign_ext,
    output logic [31:0]            ld_data,
    input  logic [LINE_BITS-1:0]   st_line,
    input  logic [OFFSET_BITS-1:0] st_offset,
    input  rw_type                 st_type,
    input  logic [31:0]            st_wdata,
    output logic [LINE_BITS-1:0]   st_line_out
);
    logic [63:0] ld_dbl;
    logic [31:0] ld_rot;
    logic [3:0]  st_mask;
    logic [7:0]  st_mask_dbl;
    logic [63:0] st_dbl;

    // Lanes rotate within the selected word, so misaligned accesses wrap instead of spilling.
    always_comb begin
        ld_dbl  = {ld_word, ld_word} >> {ld_lane, 3'b000};
        ld_rot  = ld_dbl[31:0];
        ld_data = '0;
        case (ld_type)
            RW_B:    ld_data = {{24{ld_sign_ext & ld_rot[7]}}, ld_rot[7:0]};
            RW_HALF: ld_data = {{16{ld_sign_ext & ld_rot[15]}}, ld_rot[15:0]};
            RW_WORD: ld_data = ld_rot;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        case (st_type)
            RW_B:    st_mask = 4'b0001;
            RW_HALF: st_mask = 4'b0011;
            RW_WORD: st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
        st_mask_dbl = {st_mask, st_mask} << st_offset[1:0];
        st_dbl      = {st_wdata, st_wdata} << {st_offset[1:0], 3'b000};
        st_line_out = st_line;
        for (int b = 0; b < 4; b++) begin
            if (st_mask_dbl[4 + b])
                st_line_out[{st_offset[3:2], 5'b00000} + 8 * b +: 8] = st_dbl[32 + 8 * b +: 8];
        end
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back, write-allocate data cache with a 16-byte line block-memory port.
module dcache_direct import mem_pkg::*; #(
    parameter int NUM_LINES  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    dcache_core_if.slave core,
    dcache_mem_if.master mem
);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS - IDX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [IDX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [LINE_BITS-1:0] cur_line, merged_line;
    logic [31:0]          cur_word, ld_data;
    logic                 hit, lookup, victim_dirty, fill_done;

    assign idx          = core.req_addr[OFFSET_BITS +: IDX_BITS];
    assign req_tag      = core.req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign cur_line     = data_q[idx];
    assign cur_word     = cur_line[{core.req_addr[3:2], 5'b00000} +: 32];
    assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign lookup       = (state_q == S_IDLE) && core.req_valid;
    assign fill_done    = (state_q == S_ALLOCATE) && mem.mem_ready;

    dcache_word_align u_align (
        .ld_word     (cur_word),
        .ld_lane     (core.req_addr[1:0]),
        .ld_type     (core.req_type),
        .ld_sign_ext (core.req_sign_ext),
        .ld_data     (ld_data),
        .st_line     (cur_line),
        .st_offset   (core.req_addr[OFFSET_BITS-1:0]),
        .st_type     (core.req_type),
        .st_wdata    (core.req_wdata),
        .st_line_out (merged_line)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (core.req_valid && !hit) state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (mem.mem_ready) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (mem.mem_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Stall is masked during reset so the core sees a quiet cache even with a request held.
    assign core.stall      = !rst && ((state_q != S_IDLE) || (core.req_valid && !hit));
    assign core.resp_rdata = (lookup && hit) ? ld_data : 32'd0;

    // Requests drop in the mem_ready cycle so memory never sees a second transaction.
    assign mem.mem_write = (state_q == S_WRITEBACK) && !mem.mem_ready;
    assign mem.mem_read  = (state_q == S_ALLOCATE) && !mem.mem_ready;
    assign mem.mem_wdata = (state_q == S_WRITEBACK) ? cur_line : '0;

    always_comb begin
        case (state_q)
            S_WRITEBACK: mem.mem_addr = {tag_q[idx], idx, {OFFSET_BITS{1'b0}}};
            S_ALLOCATE:  mem.mem_addr = {req_tag, idx, {OFFSET_BITS{1'b0}}};
            default:     mem.mem_addr = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (lookup && hit && core.req_we) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; valid_q alone decides whether their contents count.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= mem.mem_rdata;
        end else if (lookup && hit && core.req_we) begin
            data_q[idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench: flat byte-memory reference model plus residency predictor for dcache_direct.
module tb_dcache_direct;
    import mem_pkg::*;

    localparam int AW = 32;
    localparam int NL = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_core_if #(.ADDR_WIDTH(AW)) cif ();
    dcache_mem_if  #(.ADDR_WIDTH(AW)) mif ();

    dcache_direct #(.NUM_LINES(NL), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (cif),
        .mem  (mif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backing block memory, default contents derived from the address.
    logic [127:0] blk [logic [31:0]];
    int           lat = 2;
    int           cnt = 0;
    int           n_reads = 0, n_writes = 0, txn_seq = 0, last_rseq = 0, last_wseq = 0;
    logic [31:0]  last_raddr = '0, last_waddr = '0;
    logic [127:0] last_wdata = '0;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ (a[23:16] * 8'd3) ^ 8'h5A;
    endfunction

    function automatic logic [127:0] blk_get(logic [31:0] ba);
        logic [127:0] l;
        if (blk.exists(ba)) return blk[ba];
        for (int i = 0; i < 16; i++) l[8*i +: 8] = init_byte(ba + i);
        return l;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mif.mem_ready <= 1'b0;
            cnt           <= 0;
        end else if (mif.mem_ready) begin
            mif.mem_ready <= 1'b0;
        end else if (mif.mem_read || mif.mem_write) begin
            if (cnt >= lat - 1) begin
                cnt           <= 0;
                mif.mem_ready <= 1'b1;
                txn_seq++;
                check("mem_addr_aligned", mif.mem_addr[3:0], 4'h0);
                if (mif.mem_write) begin
                    blk[mif.mem_addr] = mif.mem_wdata;
                    n_writes++;
                    last_waddr = mif.mem_addr;
                    last_wdata = mif.mem_wdata;
                    last_wseq  = txn_seq;
                end else begin
                    mif.mem_rdata <= blk_get(mif.mem_addr);
                    n_reads++;
                    last_raddr = mif.mem_addr;
                    last_rseq  = txn_seq;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", mif.mem_read & mif.mem_write, 1'b0);
            if (mif.mem_ready) check("req_low_on_ready", mif.mem_read | mif.mem_write, 1'b0);
        end
    end

    // Reference: the cache is invisible, so the core sees a flat byte memory.
    logic [7:0]  ref_wr [logic [31:0]];
    logic [31:0] res_blk [NL];
    bit          res_v [NL];
    bit          res_d [NL];

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        logic [127:0] l;
        if (ref_wr.exists(a)) return ref_wr[a];
        l = blk_get({a[31:4], 4'h0});
        return l[{a[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] ty, bit sx);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = ref_byte({a[31:2], 2'b00} + ((a[1:0] + i) % 4));
        case (ty)
            2'd0:    return {{24{sx & b[0][7]}}, b[0]};
            2'd1:    return {{16{sx & b[1][7]}}, b[1], b[0]};
            2'd2:    return {b[3], b[2], b[1], b[0]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(logic [31:0] a, logic [1:0] ty, logic [31:0] wd);
        int n;
        n = (ty == 2'd0) ? 1 : (ty == 2'd1) ? 2 : (ty == 2'd2) ? 4 : 0;
        for (int i = 0; i < n; i++) ref_wr[{a[31:2], 2'b00} + ((a[1:0] + i) % 4)] = wd[8*i +: 8];
    endtask

    task automatic reset_model();
        ref_wr.delete();
        for (int i = 0; i < NL; i++) begin
            res_v[i] = 1'b0;
            res_d[i] = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that ends the access.
    task automatic do_access(input bit we, input logic [1:0] ty, input bit sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output int cyc);
        int          idx, r0, w0, exp_cyc;
        logic [31:0] bk, exp_ld;
        bit          miss, wb, done;
        idx     = int'(a[9:4]) % NL;
        bk      = {a[31:4], 4'h0};
        miss    = !(res_v[idx] && res_blk[idx] == bk);
        wb      = miss && res_v[idx] && res_d[idx];
        exp_cyc = !miss ? 0 : wb ? 2 * lat + 3 : lat + 2;
        exp_ld  = ref_load(a, ty, sx);
        r0 = n_reads;
        w0 = n_writes;
        cif.req_valid    = 1'b1;
        cif.req_we       = we;
        cif.req_type     = rw_type'(ty);
        cif.req_sign_ext = sx;
        cif.req_addr     = a;
        cif.req_wdata    = wd;
        cyc  = 0;
        rd   = '0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (!cif.stall) begin
                rd   = cif.resp_rdata;
                done = 1'b1;
            end else begin
                cyc++;
            end
            @(posedge clk);
            #1;
        end
        cif.req_valid = 1'b0;
        check($sformatf("completes@%h", a), done, 1'b1);
        check($sformatf("stall_cycles@%h", a), cyc, exp_cyc);
        check($sformatf("fill_count@%h", a), n_reads - r0, miss ? 1 : 0);
        check($sformatf("wb_count@%h", a), n_writes - w0, wb ? 1 : 0);
        if (miss) check($sformatf("fill_addr@%h", a), last_raddr, bk);
        if (wb) begin
            check($sformatf("wb_addr@%h", a), last_waddr, res_blk[idx]);
            check($sformatf("wb_before_fill@%h", a), last_wseq < last_rseq, 1'b1);
        end
        if (!we) check($sformatf("load_data@%h", a), rd, exp_ld);
        if (miss) begin
            res_blk[idx] = bk;
            res_v[idx]   = 1'b1;
            res_d[idx]   = 1'b0;
        end
        if (we) begin
            res_d[idx] = 1'b1;
            ref_store(a, ty, wd);
        end
    endtask

    initial begin
        logic [127:0] l;
        logic [31:0]  rd, a, wd;
        logic [1:0]   ty;
        int           cyc;
        bit           we, seen;

        l = blk_get(32'h0001_0000); l[31:0] = 32'hDEAD_BEEF; blk[32'h0001_0000] = l;
        l = blk_get(32'h1001_0000); l[31:0] = 32'h80FF_7F01; blk[32'h1001_0000] = l;
        reset_model();
        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_type = RW_WORD;
        cif.req_sign_ext = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", cif.stall, 1'b0);
        check("rst_rdata", cif.resp_rdata, 32'd0);
        check("rst_mem_read", mif.mem_read, 1'b0);
        check("rst_mem_write", mif.mem_write, 1'b0);
        check("rst_mem_addr", mif.mem_addr, 32'd0);
        check("rst_mem_wdata", mif.mem_wdata, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", cif.stall, 1'b0);
        check("idle_rdata", cif.resp_rdata, 32'd0);
        @(posedge clk);
        #1;

        // Cold load then a repeat hit.
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        check("cold_lw_data", rd, 32'hDEAD_BEEF);
        check("cold_lw_stall", cyc, 4);
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        check("repeat_lw_stall", cyc, 0);

        // Sub-word loads on a line holding 0x80FF7F01.
        do_access(0, 2'd2, 0, 32'h1001_0000, 0, rd, cyc);
        do_access(0, 2'd0, 1, 32'h1001_0000, 0, rd, cyc);
        check("lb_plus0", rd, 32'h0000_0001);
        do_access(0, 2'd0, 1, 32'h1001_0003, 0, rd, cyc);
        check("lb_plus3", rd, 32'hFFFF_FF80);
        do_access(0, 2'd1, 0, 32'h1001_0002, 0, rd, cyc);
        check("lhu_plus2", rd, 32'h0000_80FF);
        do_access(0, 2'd1, 1, 32'h1001_0002, 0, rd, cyc);
        check("lh_plus2", rd, 32'hFFFF_80FF);

        // Store hit, then dirty eviction and read-back from memory.
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        do_access(1, 2'd0, 0, 32'h0001_0001, 32'h0000_00AA, rd, cyc);
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        check("sb_merge", rd, 32'hDEAD_AAEF);
        do_access(0, 2'd2, 0, 32'h0001_0400, 0, rd, cyc);
        check("evict_wb_addr", last_waddr, 32'h0001_0000);
        check("evict_wb_data", last_wdata[31:0], 32'hDEAD_AAEF);
        check("evict_fill_addr", last_raddr, 32'h0001_0400);
        check("evict_stall", cyc, 7);
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        check("evict_readback", rd, 32'hDEAD_AAEF);

        // Random mix over four conflicting tags and four indices.
        for (int n = 0; n < 400; n++) begin
            lat = $urandom_range(1, 4);
            a   = 32'h2000_0000 | ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
                  | $urandom_range(0, 15);
            we  = ($urandom_range(0, 2) == 0);
            ty  = we ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            wd  = $urandom;
            do_access(we, ty, 1'($urandom_range(0, 1)), a, wd, rd, cyc);
        end

        // Reset mid-ALLOCATE: a dirty line and the pending fill are both lost.
        lat = 2;
        do_access(1, 2'd2, 0, 32'h0001_0000, 32'h1234_5678, rd, cyc);
        lat = 6;
        cif.req_valid = 1'b1; cif.req_we = 1'b0; cif.req_type = RW_WORD;
        cif.req_sign_ext = 1'b0; cif.req_addr = 32'h3000_0040;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mif.mem_read) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_test_read_seen", seen, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_mem_read", mif.mem_read, 1'b0);
        check("midrst_mem_write", mif.mem_write, 1'b0);
        check("midrst_stall", cif.stall, 1'b0);
        check("midrst_rdata", cif.resp_rdata, 32'd0);
        cif.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        lat = 2;
        @(posedge clk);
        #1;
        do_access(0, 2'd2, 0, 32'h3000_0040, 0, rd, cyc);
        check("post_rst_miss", cyc, 4);
        do_access(0, 2'd2, 0, 32'h0001_0000, 0, rd, cyc);
        check("dirty_lost_on_rst", rd, 32'hDEAD_AAEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
